corr_spectrum_mult: RTL and testbench

CORR_SPECTRUM_MULT -- requirements
Module: corr_spectrum_mult

---
 rtl/corr_spectrum_mult.sv | 176 +++++++++++++++++
 tb/tb_corr_spectrum_mult.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/corr_spectrum_mult.sv
// Complex spectrum multiplier for correlation: joins two AXI-Stream operand
// streams, forms a*conj(b) (or a*b), then rounds, shifts and saturates the
// product through a three-stage pipeline that stalls as a single unit.
module corr_spectrum_mult #(
    parameter int DATA_W  = 16,
    parameter int CONJ    = 1,
    parameter int SHIFT_W = 5
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [2*DATA_W-1:0]   s_a_tdata,
    input  logic                  s_a_tvalid,
    output logic                  s_a_tready,
    input  logic                  s_a_tlast,
    input  logic [2*DATA_W-1:0]   s_b_tdata,
    input  logic                  s_b_tvalid,
    output logic                  s_b_tready,
    input  logic                  s_b_tlast,
    output logic [2*DATA_W-1:0]   m_tdata,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic                  m_tlast,
    input  logic [SHIFT_W-1:0]    shift,
    input  logic                  clear_flags,
    output logic                  overflow,
    output logic                  tlast_err
);

    localparam int PW     = 2*DATA_W + 1;
    localparam int MAX_SH = 2*DATA_W;
    localparam int SH_W   = $clog2(MAX_SH + 1);
    localparam logic signed [PW:0] MAX_V = (PW+1)'(2**(DATA_W-1) - 1);
    localparam logic signed [PW:0] MIN_V = -(PW+1)'(2**(DATA_W-1));

    // The whole pipeline moves together whenever the output slot can take a beat.
    logic adv;
    logic accept;
    assign adv        = m_tready | ~m_tvalid;
    assign s_a_tready = s_b_tvalid & adv;
    assign s_b_tready = s_a_tvalid & adv;
    assign accept     = s_a_tvalid & s_b_tvalid & adv;

    logic [SH_W-1:0] shift_sat;

    // Shift amounts beyond the full product width behave as the full width.
    always_comb begin
        shift_sat = SH_W'(shift);
        if (32'(shift) > 32'(MAX_SH)) begin
            shift_sat = SH_W'(MAX_SH);
        end
    end

    logic                     s1_valid;
    logic                     s1_last;
    logic [SH_W-1:0]          s1_shift;
    logic signed [DATA_W-1:0] s1_ar, s1_ai, s1_br, s1_bi;

    // Stage 1: register the joined operands together with their own shift amount.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_shift <= '0;
            s1_ar    <= '0;
            s1_ai    <= '0;
            s1_br    <= '0;
            s1_bi    <= '0;
        end else if (adv) begin
            s1_valid <= accept;
            if (accept) begin
                s1_last  <= s_a_tlast;
                s1_shift <= shift_sat;
                s1_ar    <= s_a_tdata[DATA_W-1:0];
                s1_ai    <= s_a_tdata[2*DATA_W-1:DATA_W];
                s1_br    <= s_b_tdata[DATA_W-1:0];
                s1_bi    <= s_b_tdata[2*DATA_W-1:DATA_W];
            end
        end
    end

    logic signed [2*DATA_W-1:0] p_rr, p_ii, p_ir, p_ri;
    logic signed [PW-1:0]       re_sum, im_sum;
    assign p_rr = s1_ar * s1_br;
    assign p_ii = s1_ai * s1_bi;
    assign p_ir = s1_ai * s1_br;
    assign p_ri = s1_ar * s1_bi;

    // Partial products combine at one extra bit so no sum can wrap.
    always_comb begin
        if (CONJ != 0) begin
            re_sum = $signed({p_rr[2*DATA_W-1], p_rr}) + $signed({p_ii[2*DATA_W-1], p_ii});
            im_sum = $signed({p_ir[2*DATA_W-1], p_ir}) - $signed({p_ri[2*DATA_W-1], p_ri});
        end else begin
            re_sum = $signed({p_rr[2*DATA_W-1], p_rr}) - $signed({p_ii[2*DATA_W-1], p_ii});
            im_sum = $signed({p_ir[2*DATA_W-1], p_ir}) + $signed({p_ri[2*DATA_W-1], p_ri});
        end
    end

    logic                 s2_valid;
    logic                 s2_last;
    logic [SH_W-1:0]      s2_shift;
    logic signed [PW-1:0] s2_re, s2_im;

    // Stage 2: register the full-precision complex product.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            s2_valid <= 1'b0;
            s2_last  <= 1'b0;
            s2_shift <= '0;
            s2_re    <= '0;
            s2_im    <= '0;
        end else if (adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_last  <= s1_last;
                s2_shift <= s1_shift;
                s2_re    <= re_sum;
                s2_im    <= im_sum;
            end
        end
    end

    // Round half-up, arithmetic shift, clamp; the top bit of the result flags a clamp.
    function automatic logic [DATA_W:0] round_sat(input logic signed [PW-1:0] v,
                                                  input logic [SH_W-1:0] sh);
        logic signed [PW:0] ext;
        logic signed [PW:0] rnd;
        logic signed [PW:0] shifted;
        ext = {v[PW-1], v};
        rnd = '0;
        if (sh != '0) begin
            rnd = (PW+1)'(1) << (sh - 1'b1);
        end
        shifted = (ext + rnd) >>> sh;
        if (shifted > MAX_V) begin
            return {1'b1, MAX_V[DATA_W-1:0]};
        end else if (shifted < MIN_V) begin
            return {1'b1, MIN_V[DATA_W-1:0]};
        end
        return {1'b0, shifted[DATA_W-1:0]};
    endfunction

    logic [DATA_W:0] re_res, im_res;
    logic            ovf_set, tlast_set;
    assign re_res    = round_sat(s2_re, s2_shift);
    assign im_res    = round_sat(s2_im, s2_shift);
    assign ovf_set   = adv & s2_valid & (re_res[DATA_W] | im_res[DATA_W]);
    assign tlast_set = accept & (s_a_tlast != s_b_tlast);

    // Stage 3: output register, held while the consumer stalls.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_tvalid <= 1'b0;
            m_tlast  <= 1'b0;
            m_tdata  <= '0;
        end else if (adv) begin
            m_tvalid <= s2_valid;
            if (s2_valid) begin
                m_tlast <= s2_last;
                m_tdata <= {im_res[DATA_W-1:0], re_res[DATA_W-1:0]};
            end
        end
    end

    // Sticky flags: a new event in the same cycle as a clear keeps the flag set.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            overflow  <= 1'b0;
            tlast_err <= 1'b0;
        end else begin
            overflow  <= ovf_set   | (overflow  & ~clear_flags);
            tlast_err <= tlast_set | (tlast_err & ~clear_flags);
        end
    end

endmodule

// File: tb/tb_corr_spectrum_mult.sv
// Directed bench for corr_spectrum_mult: single-beat arithmetic cases with
// fixed-latency checks, a backpressured stream, flag behaviour and reset.
module tb_corr_spectrum_mult;

    logic        aclk;
    logic        aresetn;
    logic [31:0] s_a_tdata, s_b_tdata;
    logic        s_a_tvalid, s_a_tlast, s_b_tvalid, s_b_tlast;
    logic        s_a_tready, s_b_tready;
    logic [31:0] m_tdata;
    logic        m_tvalid, m_tlast, m_tready;
    logic [4:0]  shift;
    logic        clear_flags;
    logic        overflow, tlast_err;

    logic [31:0] m_tdata0;
    logic        m_tvalid0, m_tlast0, s_a_tready0, s_b_tready0, overflow0, tlast_err0;

    int tests;
    int fails;

    int in_idx, out_n, stall_bad, hold_bad, saw_full, stale;
    logic signed [31:0] got_re [8];
    logic signed [31:0] got_im [8];
    logic               got_last [8];
    logic [31:0]        prev_data;
    logic               prev_stalled;

    corr_spectrum_mult #(.DATA_W(16), .CONJ(1), .SHIFT_W(5)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_a_tdata(s_a_tdata), .s_a_tvalid(s_a_tvalid), .s_a_tready(s_a_tready), .s_a_tlast(s_a_tlast),
        .s_b_tdata(s_b_tdata), .s_b_tvalid(s_b_tvalid), .s_b_tready(s_b_tready), .s_b_tlast(s_b_tlast),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
        .shift(shift), .clear_flags(clear_flags), .overflow(overflow), .tlast_err(tlast_err)
    );

    corr_spectrum_mult #(.DATA_W(16), .CONJ(0), .SHIFT_W(5)) dut0 (
        .aclk(aclk), .aresetn(aresetn),
        .s_a_tdata(s_a_tdata), .s_a_tvalid(s_a_tvalid), .s_a_tready(s_a_tready0), .s_a_tlast(s_a_tlast),
        .s_b_tdata(s_b_tdata), .s_b_tvalid(s_b_tvalid), .s_b_tready(s_b_tready0), .s_b_tlast(s_b_tlast),
        .m_tdata(m_tdata0), .m_tvalid(m_tvalid0), .m_tready(m_tready), .m_tlast(m_tlast0),
        .shift(shift), .clear_flags(clear_flags), .overflow(overflow0), .tlast_err(tlast_err0)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    function automatic logic [31:0] cplx(input int re, input int im);
        return {16'(im), 16'(re)};
    endfunction

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("[TB] FAIL %s: observed %0d required %0d", tag, obs, expv);
        end
    endtask

    // One beat on both operand streams; returns at the falling edge after the handshake.
    task automatic applyStimulus(input int ar, input int ai, input int br, input int bi, input int sh);
        @(negedge aclk);
        s_a_tdata  = cplx(ar, ai);
        s_b_tdata  = cplx(br, bi);
        shift      = 5'(sh);
        s_a_tlast  = 1'b0;
        s_b_tlast  = 1'b0;
        s_a_tvalid = 1'b1;
        s_b_tvalid = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        s_a_tvalid = 1'b0;
        s_b_tvalid = 1'b0;
    endtask

    // Output must be absent for two falling edges and present on the third.
    task automatic checkOutput(input string tag, input int exp_re, input int exp_im);
        chk({tag, "_lat1"}, 32'(m_tvalid), 0);
        @(negedge aclk);
        chk({tag, "_lat2"}, 32'(m_tvalid), 0);
        @(negedge aclk);
        chk({tag, "_valid"}, 32'(m_tvalid), 1);
        chk({tag, "_re"}, $signed(m_tdata[15:0]), exp_re);
        chk({tag, "_im"}, $signed(m_tdata[31:16]), exp_im);
    endtask

    task automatic pulseClear();
        @(negedge aclk);
        clear_flags = 1'b1;
        @(negedge aclk);
        clear_flags = 1'b0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        aresetn     = 1'b0;
        s_a_tdata   = '0;
        s_b_tdata   = '0;
        s_a_tvalid  = 1'b0;
        s_b_tvalid  = 1'b1;
        s_a_tlast   = 1'b0;
        s_b_tlast   = 1'b0;
        m_tready    = 1'b1;
        shift       = '0;
        clear_flags = 1'b0;

        // Reset state; readies still follow the join rule while in reset.
        @(negedge aclk);
        @(negedge aclk);
        chk("rst_m_tvalid", 32'(m_tvalid), 0);
        chk("rst_m_tdata", m_tdata, 0);
        chk("rst_m_tlast", 32'(m_tlast), 0);
        chk("rst_overflow", 32'(overflow), 0);
        chk("rst_tlast_err", 32'(tlast_err), 0);
        chk("rst_a_tready", 32'(s_a_tready), 1);
        chk("rst_b_tready", 32'(s_b_tready), 0);
        chk("rst_a_tready0", 32'(s_a_tready0), 1);
        chk("rst_b_tready0", 32'(s_b_tready0), 0);
        s_b_tvalid = 1'b0;
        aresetn    = 1'b1;

        // (100+200j)*conj(3-4j) = -500+1000j ; (100+200j)*(3-4j) = 1100+200j
        applyStimulus(100, 200, 3, -4, 0);
        checkOutput("conj", -500, 1000);
        chk("conj_overflow", 32'(overflow), 0);
        chk("noconj_valid", 32'(m_tvalid0), 1);
        chk("noconj_re", $signed(m_tdata0[15:0]), 1100);
        chk("noconj_im", $signed(m_tdata0[31:16]), 200);
        chk("noconj_last", 32'(m_tlast0), 0);
        chk("noconj_overflow", 32'(overflow0), 0);
        chk("noconj_tlast_err", 32'(tlast_err0), 0);

        // (-32768)^2 = 2^30 saturates at shift 0, fits as 16384 at shift 16.
        applyStimulus(-32768, 0, -32768, 0, 0);
        checkOutput("sat", 32767, 0);
        chk("sat_overflow", 32'(overflow), 1);
        applyStimulus(-32768, 0, -32768, 0, 16);
        checkOutput("sh16", 16384, 0);
        chk("sh16_overflow_sticky", 32'(overflow), 1);
        pulseClear();
        chk("clear_overflow", 32'(overflow), 0);

        // Saturating beat reaches the output in the very cycle clear is asserted.
        applyStimulus(-32768, 0, -32768, 0, 0);
        @(negedge aclk);
        clear_flags = 1'b1;
        @(negedge aclk);
        clear_flags = 1'b0;
        chk("setwins_valid", 32'(m_tvalid), 1);
        chk("setwins_overflow", 32'(overflow), 1);
        pulseClear();
        chk("setwins_cleared", 32'(overflow), 0);

        // Round half-up: (3+1)>>1 = 2, (-3+1)>>>1 = -1.
        applyStimulus(3, 0, 1, 0, 1);
        checkOutput("rnd_pos", 2, 0);
        applyStimulus(-3, 0, 1, 0, 1);
        checkOutput("rnd_neg", -1, 0);
        chk("pre_stream_tlast_err", 32'(tlast_err), 0);

        // Eight-beat stream with the consumer stalled during cycles 4..8.
        in_idx = 0; out_n = 0; stall_bad = 0; hold_bad = 0; saw_full = 0;
        prev_stalled = 1'b0;
        prev_data    = '0;
        for (int k = 0; k < 8; k++) begin
            got_re[k] = '0; got_im[k] = '0; got_last[k] = 1'b0;
        end
        for (int cyc = 0; cyc < 40 && out_n < 8; cyc++) begin
            @(negedge aclk);
            m_tready = !(cyc >= 4 && cyc <= 8);
            if (in_idx < 8) begin
                s_a_tdata  = cplx(in_idx + 1, 100 + in_idx);
                s_b_tdata  = cplx(1, 0);
                s_a_tlast  = (in_idx == 7);
                s_b_tlast  = (in_idx == 4);
                s_a_tvalid = 1'b1;
                s_b_tvalid = 1'b1;
                shift      = '0;
            end else begin
                s_a_tvalid = 1'b0;
                s_b_tvalid = 1'b0;
            end
            #1;
            if (prev_stalled && m_tdata !== prev_data) hold_bad++;
            if (m_tvalid && !m_tready && in_idx < 8) begin
                if (s_a_tready || s_b_tready) stall_bad++;
                else saw_full = 1;
            end
            if (m_tvalid && m_tready) begin
                got_re[out_n]   = $signed(m_tdata[15:0]);
                got_im[out_n]   = $signed(m_tdata[31:16]);
                got_last[out_n] = m_tlast;
                out_n++;
            end
            prev_stalled = m_tvalid && !m_tready;
            prev_data    = m_tdata;
            if (s_a_tready && s_a_tvalid) in_idx++;
        end
        s_a_tvalid = 1'b0;
        s_b_tvalid = 1'b0;
        s_a_tlast  = 1'b0;
        s_b_tlast  = 1'b0;
        m_tready   = 1'b1;
        chk("stream_count", out_n, 8);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("stream%0d_re", k), got_re[k], k + 1);
            chk($sformatf("stream%0d_im", k), got_im[k], 100 + k);
            chk($sformatf("stream%0d_last", k), 32'(got_last[k]), (k == 7) ? 1 : 0);
        end
        chk("stream_stall_ready", stall_bad, 0);
        chk("stream_saw_full", saw_full, 1);
        chk("stream_hold", hold_bad, 0);
        chk("stream_tlast_err", 32'(tlast_err), 1);

        // Three beats in flight, then an asynchronous reset mid-cycle.
        for (int k = 0; k < 3; k++) begin
            @(negedge aclk);
            s_a_tdata  = (k == 0) ? cplx(-32768, 0) : cplx(5, 5);
            s_b_tdata  = (k == 0) ? cplx(-32768, 0) : cplx(1, 0);
            s_a_tlast  = 1'b0;
            s_b_tlast  = (k == 1);
            s_a_tvalid = 1'b1;
            s_b_tvalid = 1'b1;
            shift      = '0;
        end
        @(negedge aclk);
        s_a_tvalid = 1'b0;
        s_b_tvalid = 1'b0;
        s_b_tlast  = 1'b0;
        #1;
        chk("inflight_valid", 32'(m_tvalid), 1);
        chk("inflight_overflow", 32'(overflow), 1);
        aresetn = 1'b0;
        #1;
        chk("midrst_m_tvalid", 32'(m_tvalid), 0);
        chk("midrst_m_tdata", m_tdata, 0);
        chk("midrst_overflow", 32'(overflow), 0);
        chk("midrst_tlast_err", 32'(tlast_err), 0);
        @(negedge aclk);
        aresetn = 1'b1;
        stale = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge aclk);
            if (m_tvalid) stale++;
        end
        chk("post_rst_stale", stale, 0);
        applyStimulus(7, 0, 2, 0, 0);
        checkOutput("post_rst", 14, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
